// File: rtl/me_search_row_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : me_pkg
//  Description : Shared helpers and FSM state type for the motion-estimation
//                search row.
//  Revision    : 1.0 - initial release
// ============================================================================
package me_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // Index width that never collapses to zero bits
  function automatic int idx_width(input int count);
    return (count <= 2) ? 1 : clog2(count);
  endfunction

  function automatic int acc_width(input int pix_w, input int blk_size);
    return pix_w + 2 * clog2(blk_size);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/me_search_row_if.sv
`default_nettype none
// ============================================================================
//  Module      : me_search_row_if
//  Description : Control, pixel-stream and result bundle of me_search_row.
//  Revision    : 1.0 - initial release
// ============================================================================
interface me_search_row_if #(
  parameter int BLK_SIZE = 8,
  parameter int N_PE     = 8,
  parameter int PIX_W    = 8
) ();
  import me_pkg::*;

  localparam int ACC_W = acc_width(PIX_W, BLK_SIZE);
  localparam int J_W   = idx_width(N_PE);

  logic                  start;
  logic [7:0]            n_rows;
  logic                  busy;
  logic                  in_valid;
  logic                  in_ready;
  logic [PIX_W-1:0]      cur_pix;
  logic [N_PE*PIX_W-1:0] ref_pix;
  logic                  done;
  logic [ACC_W-1:0]      best_sad;
  logic [7:0]            best_i;
  logic [J_W-1:0]        best_j;

  modport master (
    output start, n_rows, in_valid, cur_pix, ref_pix,
    input  busy, in_ready, done, best_sad, best_i, best_j
  );

  modport slave (
    input  start, n_rows, in_valid, cur_pix, ref_pix,
    output busy, in_ready, done, best_sad, best_i, best_j
  );

endinterface
`default_nettype wire

// File: rtl/me_search_row_sad_pe.sv
`default_nettype none
// ============================================================================
//  Module      : sad_pe
//  Description : Three-stage |cur - ref| accumulator; first beat loads.
//  Revision    : 1.0 - initial release
// ============================================================================
module sad_pe #(
  parameter int PIX_W = 8,
  parameter int ACC_W = 14
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             first,
  input  logic [PIX_W-1:0] cur_pix,
  input  logic [PIX_W-1:0] ref_pix,
  output logic [ACC_W-1:0] acc
);

  logic             r_v1, r_f1, r_v2, r_f2;
  logic [PIX_W:0]   r_diff;
  logic [PIX_W:0]   w_neg;
  logic [PIX_W-1:0] r_abs;
  logic [ACC_W-1:0] r_acc;

  assign w_neg = -r_diff;
  assign acc   = r_acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v1   <= 1'b0;
      r_f1   <= 1'b0;
      r_v2   <= 1'b0;
      r_f2   <= 1'b0;
      r_diff <= '0;
      r_abs  <= '0;
      r_acc  <= '0;
    end else begin
      r_v1 <= en;
      r_v2 <= r_v1;
      if (en) begin
        r_f1   <= first;
        r_diff <= {1'b0, cur_pix} - {1'b0, ref_pix};
      end
      if (r_v1) begin
        r_f2  <= r_f1;
        r_abs <= r_diff[PIX_W] ? w_neg[PIX_W-1:0] : r_diff[PIX_W-1:0];
      end
      if (r_v2) begin
        r_acc <= r_f2 ? ACC_W'(r_abs) : r_acc + ACC_W'(r_abs);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/me_search_row.sv
`default_nettype none
// ============================================================================
//  Module      : me_search_row
//  Description : Block-matching row engine: N_PE SAD PEs, row capture buffer
//                and a minimum-SAD scan that overlaps the next row.
//  Revision    : 1.0 - initial release
// ============================================================================
module me_search_row
  import me_pkg::*;
#(
  parameter int BLK_SIZE = 8,
  parameter int N_PE     = 8,
  parameter int PIX_W    = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  me_search_row_if.slave bus
);

  localparam int BLK_SQ = BLK_SIZE * BLK_SIZE;
  localparam int ACC_W  = acc_width(PIX_W, BLK_SIZE);
  localparam int J_W    = idx_width(N_PE);
  localparam int B_W    = idx_width(BLK_SQ);
  localparam logic [B_W-1:0] C_LAST_BEAT = B_W'(BLK_SQ - 1);
  localparam logic [J_W-1:0] C_LAST_PE   = J_W'(N_PE - 1);

  state_t           r_state;
  logic [B_W-1:0]   r_beat_cnt;
  logic [7:0]       r_row_cnt, r_rows, r_fin_row, r_buf_row;
  logic [2:0]       r_fin_pipe;
  logic             r_scan_active, r_cand_valid;
  logic [J_W-1:0]   r_scan_idx, r_cand_j, r_best_j;
  logic [ACC_W-1:0] r_buf [N_PE];
  logic [ACC_W-1:0] r_cand_sad, r_best_sad;
  logic [7:0]       r_cand_i, r_best_i;
  logic [ACC_W-1:0] w_acc [N_PE];
  logic             w_start, w_ready, w_accept, w_last_beat, w_last_row, w_first;

  assign w_start     = bus.start && (r_state == ST_IDLE);
  assign w_last_beat = (r_beat_cnt == C_LAST_BEAT);
  assign w_last_row  = (r_row_cnt == r_rows - 8'd1);
  assign w_first     = (r_beat_cnt == '0);
  // Hold a row's final beat while the buffer still serves the previous scan
  assign w_ready     = (r_state == ST_RUN) && !(w_last_beat && r_scan_active);
  assign w_accept    = bus.in_valid && w_ready;

  assign bus.in_ready = w_ready;
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.done     = (r_state == ST_DONE);
  assign bus.best_sad = r_best_sad;
  assign bus.best_i   = r_best_i;
  assign bus.best_j   = r_best_j;

  generate
    for (genvar j = 0; j < N_PE; j++) begin : g_pe
      sad_pe #(.PIX_W(PIX_W), .ACC_W(ACC_W)) u_pe (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (w_accept),
        .first   (w_first),
        .cur_pix (bus.cur_pix),
        .ref_pix (bus.ref_pix[j*PIX_W +: PIX_W]),
        .acc     (w_acc[j])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_beat_cnt <= '0;
      r_row_cnt  <= '0;
      r_rows     <= 8'd1;
      r_fin_row  <= '0;
      r_fin_pipe <= '0;
    end else begin
      // Tracks a finished row through the three PE stages
      r_fin_pipe <= {r_fin_pipe[1:0], w_accept && w_last_beat};
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state    <= ST_RUN;
            r_rows     <= (bus.n_rows == 8'd0) ? 8'd1 : bus.n_rows;
            r_beat_cnt <= '0;
            r_row_cnt  <= '0;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            if (w_last_beat) begin
              r_beat_cnt <= '0;
              r_row_cnt  <= r_row_cnt + 8'd1;
              r_fin_row  <= r_row_cnt;
              if (w_last_row) r_state <= ST_DRAIN;
            end else begin
              r_beat_cnt <= r_beat_cnt + B_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (r_fin_pipe == 3'b000 && !r_scan_active && !r_cand_valid) r_state <= ST_DONE;
        end
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_fin_pipe[2]) begin
      for (int k = 0; k < N_PE; k++) r_buf[k] <= w_acc[k];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf_row     <= '0;
      r_scan_active <= 1'b0;
      r_scan_idx    <= '0;
      r_cand_valid  <= 1'b0;
      r_cand_sad    <= '0;
      r_cand_i      <= '0;
      r_cand_j      <= '0;
      r_best_sad    <= '1;
      r_best_i      <= '0;
      r_best_j      <= '0;
    end else begin
      if (r_fin_pipe[2]) begin
        r_buf_row     <= r_fin_row;
        r_scan_active <= 1'b1;
        r_scan_idx    <= '0;
      end else if (r_scan_active) begin
        r_scan_idx <= r_scan_idx + J_W'(1);
        if (r_scan_idx == C_LAST_PE) r_scan_active <= 1'b0;
      end
      r_cand_valid <= r_scan_active;
      r_cand_sad   <= r_buf[r_scan_idx];
      r_cand_i     <= r_buf_row;
      r_cand_j     <= r_scan_idx;
      // Strict less-than keeps the earliest candidate on ties
      if (w_start) begin
        r_best_sad <= '1;
        r_best_i   <= '0;
        r_best_j   <= '0;
      end else if (r_cand_valid && (r_cand_sad < r_best_sad)) begin
        r_best_sad <= r_cand_sad;
        r_best_i   <= r_cand_i;
        r_best_j   <= r_cand_j;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_me_search_row.sv
`default_nettype none
// ============================================================================
//  Module      : tb_me_search_row
//  Description : Directed scoreboard bench for three me_search_row configs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_me_search_row;
  import me_pkg::*;

  typedef struct { int sad; int i; int j; } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   stall_cnt = 0;
  exp_t sb[$];
  int   cur_mem [4][64];
  int   ref_mem [4][64][8];

  me_search_row_if #(.BLK_SIZE(2), .N_PE(4), .PIX_W(8)) ia ();
  me_search_row_if #(.BLK_SIZE(2), .N_PE(8), .PIX_W(8)) ib ();
  me_search_row_if #(.BLK_SIZE(8), .N_PE(4), .PIX_W(8)) ic ();

  me_search_row #(.BLK_SIZE(2), .N_PE(4), .PIX_W(8)) ua (.clk(clk), .reset_n(reset_n), .bus(ia.slave));
  me_search_row #(.BLK_SIZE(2), .N_PE(8), .PIX_W(8)) ub (.clk(clk), .reset_n(reset_n), .bus(ib.slave));
  me_search_row #(.BLK_SIZE(8), .N_PE(4), .PIX_W(8)) uc (.clk(clk), .reset_n(reset_n), .bus(ic.slave));

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int rd(input int inst, input int f);
    int v[6];
    case (inst)
      0: begin v[0] = int'(ia.busy); v[1] = int'(ia.in_ready); v[2] = int'(ia.done);
               v[3] = int'(ia.best_sad); v[4] = int'(ia.best_i); v[5] = int'(ia.best_j); end
      1: begin v[0] = int'(ib.busy); v[1] = int'(ib.in_ready); v[2] = int'(ib.done);
               v[3] = int'(ib.best_sad); v[4] = int'(ib.best_i); v[5] = int'(ib.best_j); end
      default: begin v[0] = int'(ic.busy); v[1] = int'(ic.in_ready); v[2] = int'(ic.done);
               v[3] = int'(ic.best_sad); v[4] = int'(ic.best_i); v[5] = int'(ic.best_j); end
    endcase
    return v[f];
  endfunction

  task automatic set_ctl(input int inst, input logic st, input logic [7:0] nr);
    case (inst)
      0: begin ia.start = st; ia.n_rows = nr; end
      1: begin ib.start = st; ib.n_rows = nr; end
      default: begin ic.start = st; ic.n_rows = nr; end
    endcase
  endtask

  task automatic set_beat(input int inst, input logic v, input logic [7:0] c, input logic [63:0] r);
    case (inst)
      0: begin ia.in_valid = v; ia.cur_pix = c; ia.ref_pix = r[31:0]; end
      1: begin ib.in_valid = v; ib.cur_pix = c; ib.ref_pix = r; end
      default: begin ic.in_valid = v; ic.cur_pix = c; ic.ref_pix = r[31:0]; end
    endcase
  endtask

  function automatic logic [63:0] ref_word(input int r, input int b, input int npe);
    logic [63:0] w;
    w = '0;
    for (int j = 0; j < npe; j++) w[j*8 +: 8] = 8'(ref_mem[r][b][j]);
    return w;
  endfunction

  function automatic exp_t model(input int nrows, input int blksq, input int npe);
    exp_t e;
    int   n, s, c, rf;
    e.sad = 32'h7fffffff; e.i = 0; e.j = 0;
    n = (nrows == 0) ? 1 : nrows;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < npe; j++) begin
        s = 0;
        for (int b = 0; b < blksq; b++) begin
          c = cur_mem[i][b]; rf = ref_mem[i][b][j];
          s += (c > rf) ? (c - rf) : (rf - c);
        end
        if (s < e.sad) begin e.sad = s; e.i = i; e.j = j; end
      end
    return e;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, rd(0, 0), 0);
    check({tag, "_ready"}, rd(0, 1), 0);
    check({tag, "_done"}, rd(0, 2), 0);
    check({tag, "_sad"}, rd(0, 3), 1023);
    check({tag, "_i"}, rd(0, 4), 0);
    check({tag, "_j"}, rd(0, 5), 0);
  endtask

  task automatic do_start(input int inst, input int nrows);
    set_ctl(inst, 1'b1, 8'(nrows));
    @(posedge clk); #1;
    set_ctl(inst, 1'b0, 8'd7);
    check("busy_after_start", rd(inst, 0), 1);
    check("ready_after_start", rd(inst, 1), 1);
  endtask

  // Called just after a rising edge; returns just after the accepting edge
  task automatic send_beat(input int inst, input int r, input int b, input int npe);
    int guard;
    guard = 0;
    set_beat(inst, 1'b1, 8'(cur_mem[r][b]), ref_word(r, b, npe));
    while (rd(inst, 1) == 0 && guard < 500) begin
      stall_cnt++; guard++;
      @(posedge clk); #1;
    end
    if (guard >= 500) check("ready_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_search(input int inst, input int nrows, input int blksq, input int npe, input string tag);
    exp_t e;
    int   n, lat, exp_stall;
    sb.push_back(model(nrows, blksq, npe));
    n = (nrows == 0) ? 1 : nrows;
    exp_stall = (npe + 4 > blksq) ? (n - 1) * (npe + 4 - blksq) : 0;
    stall_cnt = 0;
    do_start(inst, nrows);
    for (int r = 0; r < n; r++)
      for (int b = 0; b < blksq; b++) begin
        if (r == 0 && b == 1) set_ctl(inst, 1'b1, 8'd1);
        send_beat(inst, r, b, npe);
        set_ctl(inst, 1'b0, 8'd7);
      end
    set_beat(inst, 1'b0, 8'd0, 64'd0);
    lat = 0;
    while (lat < 400 && rd(inst, 2) == 0) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, npe + 5);
    check({tag, "_stalls"}, stall_cnt, exp_stall);
    e = sb.pop_front();
    check({tag, "_sad"}, rd(inst, 3), e.sad);
    check({tag, "_i"}, rd(inst, 4), e.i);
    check({tag, "_j"}, rd(inst, 5), e.j);
    set_ctl(inst, 1'b1, 8'd1);
    @(posedge clk); #1;
    set_ctl(inst, 1'b0, 8'd7);
    check({tag, "_start_in_done_ignored"}, rd(inst, 0), 0);
    check({tag, "_sad_hold"}, rd(inst, 3), e.sad);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      set_ctl(k, 1'b0, 8'd0);
      set_beat(k, 1'b0, 8'd0, 64'd0);
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // Single row, exact match on PE 0
    for (int b = 0; b < 4; b++) begin
      cur_mem[0][b] = 10;
      for (int j = 0; j < 4; j++) ref_mem[0][b][j] = 10 + j;
    end
    run_search(0, 1, 4, 4, "t1");

    // Exact match hidden at row 1, PE 2
    for (int r = 0; r < 3; r++)
      for (int b = 0; b < 4; b++) begin
        cur_mem[r][b] = 20 + 7 * b;
        for (int j = 0; j < 4; j++) ref_mem[r][b][j] = (r == 1 && j == 2) ? cur_mem[r][b] : cur_mem[r][b] + 5;
      end
    run_search(0, 3, 4, 4, "t2");

    // Ties: row0 PE1/PE3 and row2 PE0 all sum to 4
    for (int r = 0; r < 3; r++)
      for (int b = 0; b < 4; b++) begin
        cur_mem[r][b] = 50 + b;
        for (int j = 0; j < 4; j++)
          ref_mem[r][b][j] = cur_mem[r][b] +
            ((r == 0) ? ((j % 2 == 1) ? 1 : 2) : ((r == 2 && j == 0) ? 1 : 3));
      end
    run_search(0, 3, 4, 4, "t3");

    // Eight PEs on a 2x2 block: final beat of row 1 must wait for the scan
    for (int r = 0; r < 2; r++)
      for (int b = 0; b < 4; b++) begin
        cur_mem[r][b] = int'($urandom_range(0, 255));
        for (int j = 0; j < 8; j++) ref_mem[r][b][j] = int'($urandom_range(0, 255));
      end
    run_search(1, 2, 4, 8, "t4");

    // Full-scale differences, n_rows of 0 behaves as one row
    for (int b = 0; b < 64; b++) begin
      cur_mem[0][b] = 255;
      for (int j = 0; j < 4; j++) ref_mem[0][b][j] = 0;
    end
    run_search(2, 0, 64, 4, "t5");
    check("t5_max_sad", rd(2, 3), 16320);

    // Abort a search part-way through a row
    for (int r = 0; r < 2; r++)
      for (int b = 0; b < 4; b++) begin
        cur_mem[r][b] = 90;
        for (int j = 0; j < 4; j++) ref_mem[r][b][j] = 90;
      end
    do_start(0, 2);
    for (int b = 0; b < 3; b++) send_beat(0, 0, b, 4);
    reset_n = 1'b0;
    #1;
    check_reset("mid_reset");
    set_beat(0, 1'b0, 8'd0, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    for (int b = 0; b < 4; b++) begin
      cur_mem[0][b] = 100;
      for (int j = 0; j < 4; j++) ref_mem[0][b][j] = (j == 3) ? 101 : 102;
    end
    run_search(0, 1, 4, 4, "t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
